// File: rtl/l1_dcache_pkg.sv
// Shared types and helpers for the direct-mapped L1 data cache.
package l1_dcache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB_REQ,
    WB_WAIT,
    FILL,
    RESP
  } state_e;

  // Field widths for the default geometry (64-bit words, 8-word lines, 64 sets)
  localparam int unsigned DEF_DATA_WIDTH = 64;
  localparam int unsigned DEF_ADDR_WIDTH = 64;
  localparam int unsigned DEF_CHUNKS_LOG = 3;
  localparam int unsigned DEF_SETS       = 64;
  localparam int unsigned OFF_W  = $clog2(DEF_DATA_WIDTH / 8);
  localparam int unsigned WORD_W = DEF_CHUNKS_LOG;
  localparam int unsigned IDX_W  = $clog2(DEF_SETS);
  localparam int unsigned TAG_W  = DEF_ADDR_WIDTH - IDX_W - WORD_W - OFF_W;

  // Helpers operate on wide containers; callers size-cast in and out
  localparam int unsigned MAX_AW = 128;
  localparam int unsigned MAX_DW = 1024;
  localparam int unsigned MAX_SB = MAX_DW / 8;

  // Rebuild a line-aligned byte address from its tag and index fields
  function automatic logic [MAX_AW-1:0] line_addr(input logic [MAX_AW-1:0] tag,
                                                  input logic [MAX_AW-1:0] idx,
                                                  input int unsigned idx_lsb,
                                                  input int unsigned tag_lsb);
    return (tag << tag_lsb) | (idx << idx_lsb);
  endfunction

  // Replace the bytes of old_w selected by strb with the bytes of new_w
  function automatic logic [MAX_DW-1:0] strb_merge(input logic [MAX_DW-1:0] old_w,
                                                   input logic [MAX_DW-1:0] new_w,
                                                   input logic [MAX_SB-1:0] strb);
    logic [MAX_DW-1:0] r;
    r = old_w;
    for (int unsigned b = 0; b < MAX_SB; b++) begin
      if (strb[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/l1_dcache_direct_if.sv
// Core-side request/response, arbiter command/bus and snoop signals of the L1 data cache.
interface l1_dcache_direct_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned CHUNKS_LOG = 3
);
  localparam int unsigned LINE_W = DATA_WIDTH << CHUNKS_LOG;

  logic                    cpu_req_valid;
  logic                    cpu_req_ready;
  logic                    cpu_req_store;
  logic [ADDR_WIDTH-1:0]   cpu_req_addr;
  logic [DATA_WIDTH-1:0]   cpu_req_wdata;
  logic [DATA_WIDTH/8-1:0] cpu_req_wstrb;
  logic                    cpu_resp_valid;
  logic [DATA_WIDTH-1:0]   cpu_resp_rdata;
  logic                    mem_cmd_valid;
  logic                    mem_cmd_store;
  logic                    mem_cmd_rready;
  logic [ADDR_WIDTH-1:0]   mem_cmd_addr;
  logic [LINE_W-1:0]       mem_cmd_line;
  logic                    mem_bus_valid;
  logic                    mem_bus_ready;
  logic [LINE_W-1:0]       mem_bus_line;
  logic                    inv_valid;
  logic [ADDR_WIDTH-1:0]   inv_addr;

  // Cache side
  modport slave (
    input  cpu_req_valid, cpu_req_store, cpu_req_addr, cpu_req_wdata, cpu_req_wstrb,
    input  mem_bus_valid, mem_bus_ready, mem_bus_line, inv_valid, inv_addr,
    output cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
    output mem_cmd_valid, mem_cmd_store, mem_cmd_rready, mem_cmd_addr, mem_cmd_line
  );

  // Core / arbiter side
  modport master (
    output cpu_req_valid, cpu_req_store, cpu_req_addr, cpu_req_wdata, cpu_req_wstrb,
    output mem_bus_valid, mem_bus_ready, mem_bus_line, inv_valid, inv_addr,
    input  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
    input  mem_cmd_valid, mem_cmd_store, mem_cmd_rready, mem_cmd_addr, mem_cmd_line
  );
endinterface

// File: rtl/l1_dcache_tag_array.sv
// Valid/dirty/tag storage with lookup compare and snoop-invalidate match.
module l1_dcache_tag_array #(
  parameter int unsigned IDX_BITS = 6,
  parameter int unsigned TAG_BITS = 52
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_BITS-1:0] lk_idx_i,
  input  logic [TAG_BITS-1:0] lk_tag_i,
  output logic                lk_hit_o,
  output logic                victim_dirty_o,
  output logic [TAG_BITS-1:0] victim_tag_o,
  input  logic                inv_valid_i,
  input  logic [IDX_BITS-1:0] inv_idx_i,
  input  logic [TAG_BITS-1:0] inv_tag_i,
  input  logic                set_dirty_i,
  input  logic                clr_dirty_i,
  input  logic                inst_i,
  input  logic                inst_valid_i,
  input  logic                inst_dirty_i
);
  localparam int unsigned SETS = 1 << IDX_BITS;

  logic [SETS-1:0]     valid_q;
  logic [SETS-1:0]     dirty_q;
  logic [TAG_BITS-1:0] tag_q [SETS];
  logic                inv_hit;
  logic                victim_valid;

  // A line being snooped away this cycle is neither a hit nor a victim to write back
  assign inv_hit        = inv_valid_i && valid_q[inv_idx_i] && (tag_q[inv_idx_i] == inv_tag_i);
  assign victim_valid   = valid_q[lk_idx_i] && !(inv_hit && (inv_idx_i == lk_idx_i));
  assign victim_dirty_o = victim_valid && dirty_q[lk_idx_i];
  assign victim_tag_o   = tag_q[lk_idx_i];
  assign lk_hit_o       = victim_valid && (tag_q[lk_idx_i] == lk_tag_i);

  // Line state; an install after an invalidate of the same index wins
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (inv_hit) begin
        valid_q[inv_idx_i] <= 1'b0;
        dirty_q[inv_idx_i] <= 1'b0;
      end
      if (set_dirty_i) dirty_q[lk_idx_i] <= 1'b1;
      if (clr_dirty_i) dirty_q[lk_idx_i] <= 1'b0;
      if (inst_i) begin
        valid_q[lk_idx_i] <= inst_valid_i;
        dirty_q[lk_idx_i] <= inst_dirty_i;
      end
    end
  end

  // Tags are written on install only
  always_ff @(posedge clk) begin
    if (inst_i) tag_q[lk_idx_i] <= lk_tag_i;
  end
endmodule

// File: rtl/l1_dcache_direct.sv
// Direct-mapped write-back, write-allocate L1 data cache with line-granular refill.
module l1_dcache_direct
  import l1_dcache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned CHUNKS_LOG = 3,
  parameter int unsigned SETS       = 64
) (
  input logic clk,
  input logic reset,
  l1_dcache_direct_if.slave bus
);
  localparam int unsigned LINE_W   = DATA_WIDTH << CHUNKS_LOG;
  localparam int unsigned OFF_BITS = $clog2(DATA_WIDTH / 8);
  localparam int unsigned IDX_BITS = $clog2(SETS);
  localparam int unsigned IDX_LSB  = OFF_BITS + CHUNKS_LOG;
  localparam int unsigned TAG_LSB  = IDX_LSB + IDX_BITS;
  localparam int unsigned TAG_BITS = ADDR_WIDTH - TAG_LSB;

  state_e                        state_q;
  logic                          req_store_q;
  logic [ADDR_WIDTH-1:OFF_BITS]  req_waddr_q;
  logic [DATA_WIDTH-1:0]         req_wdata_q;
  logic [DATA_WIDTH/8-1:0]       req_wstrb_q;
  logic                          poison_q;
  logic [LINE_W-1:0]             data_q [SETS];

  logic [CHUNKS_LOG-1:0] req_word;
  logic [IDX_BITS-1:0]   req_idx, inv_idx;
  logic [TAG_BITS-1:0]   req_tag, inv_tag, victim_tag;
  logic                  lk_hit, victim_dirty, poison_now, fill_take;
  logic [LINE_W-1:0]     line_now, fill_line;
  logic [DATA_WIDTH-1:0] word_old, merged_word, fill_word;

  assign req_word   = req_waddr_q[OFF_BITS +: CHUNKS_LOG];
  assign req_idx    = req_waddr_q[IDX_LSB +: IDX_BITS];
  assign req_tag    = req_waddr_q[TAG_LSB +: TAG_BITS];
  assign inv_idx    = bus.inv_addr[IDX_LSB +: IDX_BITS];
  assign inv_tag    = bus.inv_addr[TAG_LSB +: TAG_BITS];
  assign poison_now = bus.inv_valid && (inv_idx == req_idx) && (inv_tag == req_tag);
  assign fill_take  = !reset && (state_q == FILL) && bus.mem_bus_valid;

  assign line_now    = data_q[req_idx];
  assign word_old    = line_now[req_word*DATA_WIDTH +: DATA_WIDTH];
  assign merged_word = DATA_WIDTH'(strb_merge(MAX_DW'(word_old), MAX_DW'(req_wdata_q),
                                              MAX_SB'(req_wstrb_q)));

  l1_dcache_tag_array #(
    .IDX_BITS(IDX_BITS),
    .TAG_BITS(TAG_BITS)
  ) u_tags (
    .clk           (clk),
    .reset         (reset),
    .lk_idx_i      (req_idx),
    .lk_tag_i      (req_tag),
    .lk_hit_o      (lk_hit),
    .victim_dirty_o(victim_dirty),
    .victim_tag_o  (victim_tag),
    .inv_valid_i   (bus.inv_valid),
    .inv_idx_i     (inv_idx),
    .inv_tag_i     (inv_tag),
    .set_dirty_i   (!reset && (state_q == LOOKUP) && lk_hit && req_store_q),
    .clr_dirty_i   (!reset && (state_q == WB_WAIT) && bus.mem_bus_ready),
    .inst_i        (fill_take),
    .inst_valid_i  (!(poison_q || poison_now)),
    .inst_dirty_i  (req_store_q)
  );

  // Incoming fill line with pending store data folded into the requested word
  always_comb begin
    fill_line = bus.mem_bus_line;
    fill_word = DATA_WIDTH'(strb_merge(MAX_DW'(bus.mem_bus_line[req_word*DATA_WIDTH +: DATA_WIDTH]),
                                       MAX_DW'(req_wdata_q), MAX_SB'(req_wstrb_q)));
    if (req_store_q) fill_line[req_word*DATA_WIDTH +: DATA_WIDTH] = fill_word;
  end

  // Controller: request capture, hit/miss sequencing, fill poisoning
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      req_store_q <= 1'b0;
      req_waddr_q <= '0;
      req_wdata_q <= '0;
      req_wstrb_q <= '0;
      poison_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.cpu_req_valid) begin
          req_store_q <= bus.cpu_req_store;
          req_waddr_q <= bus.cpu_req_addr[ADDR_WIDTH-1:OFF_BITS];
          req_wdata_q <= bus.cpu_req_wdata;
          req_wstrb_q <= bus.cpu_req_wstrb;
          poison_q    <= 1'b0;
          state_q     <= LOOKUP;
        end
        LOOKUP: begin
          if (lk_hit)            state_q <= IDLE;
          else if (victim_dirty) state_q <= WB_REQ;
          else                   state_q <= FILL;
        end
        WB_REQ:  if (!bus.mem_bus_ready) state_q <= WB_WAIT;
        WB_WAIT: if (bus.mem_bus_ready)  state_q <= FILL;
        FILL: begin
          if (poison_now)        poison_q <= 1'b1;
          if (bus.mem_bus_valid) state_q  <= RESP;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Data array: store-hit word merge and whole-line install
  always_ff @(posedge clk) begin
    if (!reset && (state_q == LOOKUP) && lk_hit && req_store_q)
      data_q[req_idx][req_word*DATA_WIDTH +: DATA_WIDTH] <= merged_word;
    if (fill_take) data_q[req_idx] <= fill_line;
  end

  // Output decode from the registered state; everything forced low during reset
  always_comb begin
    bus.cpu_req_ready  = !reset && (state_q == IDLE);
    bus.cpu_resp_valid = 1'b0;
    bus.cpu_resp_rdata = '0;
    bus.mem_cmd_valid  = 1'b0;
    bus.mem_cmd_store  = 1'b0;
    bus.mem_cmd_rready = 1'b0;
    bus.mem_cmd_addr   = '0;
    bus.mem_cmd_line   = '0;
    if (!reset) begin
      case (state_q)
        LOOKUP: if (lk_hit) begin
          bus.cpu_resp_valid = 1'b1;
          bus.cpu_resp_rdata = req_store_q ? '0 : word_old;
        end
        WB_REQ: begin
          bus.mem_cmd_valid = 1'b1;
          bus.mem_cmd_store = 1'b1;
          bus.mem_cmd_addr  = ADDR_WIDTH'(line_addr(MAX_AW'(victim_tag), MAX_AW'(req_idx),
                                                    IDX_LSB, TAG_LSB));
          bus.mem_cmd_line  = line_now;
        end
        FILL: begin
          bus.mem_cmd_valid  = 1'b1;
          bus.mem_cmd_addr   = ADDR_WIDTH'(line_addr(MAX_AW'(req_tag), MAX_AW'(req_idx),
                                                     IDX_LSB, TAG_LSB));
          bus.mem_cmd_rready = bus.mem_bus_valid;
        end
        RESP: begin
          bus.cpu_resp_valid = 1'b1;
          bus.cpu_resp_rdata = req_store_q ? '0 : word_old;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_l1_dcache_direct.sv
// Directed bench for l1_dcache_direct with a small arbiter/memory responder.
module tb_l1_dcache_direct;
  localparam int unsigned DW   = 64;
  localparam int unsigned AW   = 64;
  localparam int unsigned CL   = 3;
  localparam int unsigned SETS = 64;
  localparam int unsigned LW   = DW << CL;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  l1_dcache_direct_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CHUNKS_LOG(CL)) bus ();

  l1_dcache_direct #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CHUNKS_LOG(CL), .SETS(SETS)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Backing memory: unwritten lines hold the byte address of each word
  logic [LW-1:0] mem_q [logic [63:0]];

  function automatic logic [LW-1:0] mem_read(input logic [63:0] la);
    logic [LW-1:0] l;
    if (mem_q.exists(la)) return mem_q[la];
    for (int w = 0; w < 8; w++) l[w*64 +: 64] = la + 64'(w * 8);
    return l;
  endfunction

  int            arb_st = 0;
  int            arb_cnt = 0;
  int            fill_cnt = 0;
  int            wb_cnt = 0;
  logic [63:0]   fill_addr_log = '0;
  logic [63:0]   wb_addr_log = '0;
  logic [LW-1:0] wb_line_log = '0;

  // Arbiter model: writeback takes 2 busy cycles, fill data appears 3 cycles after the command
  initial begin
    bus.mem_bus_ready = 1'b1;
    bus.mem_bus_valid = 1'b0;
    bus.mem_bus_line  = '0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        bus.mem_bus_ready = 1'b1;
        bus.mem_bus_valid = 1'b0;
        arb_st = 0;
      end else begin
        case (arb_st)
          0: if (bus.mem_cmd_valid) begin
            bus.mem_bus_ready = 1'b0;
            if (bus.mem_cmd_store) begin
              mem_q[bus.mem_cmd_addr] = bus.mem_cmd_line;
              wb_addr_log = bus.mem_cmd_addr;
              wb_line_log = bus.mem_cmd_line;
              wb_cnt++;
              arb_cnt = 2;
              arb_st  = 1;
            end else begin
              fill_addr_log = bus.mem_cmd_addr;
              fill_cnt++;
              arb_cnt = 3;
              arb_st  = 2;
            end
          end
          1: begin
            arb_cnt--;
            if (arb_cnt == 0) begin
              bus.mem_bus_ready = 1'b1;
              arb_st = 0;
            end
          end
          2: begin
            arb_cnt--;
            if (arb_cnt == 0) begin
              bus.mem_bus_valid = 1'b1;
              bus.mem_bus_line  = mem_read(fill_addr_log);
              arb_st = 3;
              #1 check_eq("rready", 64'(bus.mem_cmd_rready), 64'd1);
            end
          end
          default: begin
            bus.mem_bus_valid = 1'b0;
            bus.mem_bus_ready = 1'b1;
            arb_st = 0;
            check_eq("cmd_drop", 64'(bus.mem_cmd_valid), 64'd0);
          end
        endcase
      end
    end
  end

  // One core access; returns load data and cycles from acceptance to response
  task automatic cpu_access(input logic st, input logic [63:0] addr, input logic [63:0] wd,
                            input logic [7:0] ws, output logic [63:0] rd, output int lat);
    int n;
    n = 0;
    while (!bus.cpu_req_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n == 50) check_eq("ready_to", 64'(bus.cpu_req_ready), 64'd1);
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_store = st;
    bus.cpu_req_addr  = addr;
    bus.cpu_req_wdata = wd;
    bus.cpu_req_wstrb = ws;
    @(posedge clk); #1;
    bus.cpu_req_valid = 1'b0;
    lat = 1;
    while (!bus.cpu_resp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    if (!bus.cpu_resp_valid) check_eq("resp_to", 64'(bus.cpu_resp_valid), 64'd1);
    rd = bus.cpu_resp_rdata;
    @(posedge clk); #1;
    check_eq("pulse", 64'(bus.cpu_resp_valid), 64'd0);
  endtask

  task automatic do_load(input string tag, input logic [63:0] addr, input logic [63:0] exp,
                         input bit hit);
    logic [63:0] rd;
    int          lat;
    cpu_access(1'b0, addr, '0, '0, rd, lat);
    check_eq({tag, "_data"}, rd, exp);
    if (hit) check_eq({tag, "_lat"}, 64'(lat), 64'd1);
    else     check_eq({tag, "_miss"}, 64'(lat > 1), 64'd1);
  endtask

  task automatic do_store(input string tag, input logic [63:0] addr, input logic [63:0] wd,
                          input logic [7:0] ws);
    logic [63:0] rd;
    int          lat;
    cpu_access(1'b1, addr, wd, ws, rd, lat);
    check_eq({tag, "_data"}, rd, 64'd0);
    check_eq({tag, "_lat"}, 64'(lat), 64'd1);
  endtask

  task automatic inv_pulse(input logic [63:0] addr);
    bus.inv_valid = 1'b1;
    bus.inv_addr  = addr;
    @(posedge clk); #1;
    bus.inv_valid = 1'b0;
  endtask

  task automatic wait_fill(input logic [63:0] addr);
    int n;
    n = 0;
    while (!(bus.mem_cmd_valid && !bus.mem_cmd_store && bus.mem_cmd_addr == addr) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check_eq("fill_seen", bus.mem_cmd_addr, addr);
  endtask

  logic [LW-1:0] pre_line;
  int            f0;

  initial begin
    bus.cpu_req_valid = 1'b0;
    bus.cpu_req_store = 1'b0;
    bus.cpu_req_addr  = '0;
    bus.cpu_req_wdata = '0;
    bus.cpu_req_wstrb = '0;
    bus.inv_valid     = 1'b0;
    bus.inv_addr      = '0;
    pre_line = mem_read(64'h1000);
    pre_line[64 +: 64]  = 64'hAA;
    pre_line[128 +: 64] = 64'h1122_3344_5566_7788;
    mem_q[64'h1000] = pre_line;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", 64'(bus.cpu_req_ready), 64'd0);
    check_eq("rst_cmd", 64'(bus.mem_cmd_valid), 64'd0);
    check_eq("rst_resp", 64'(bus.cpu_resp_valid), 64'd0);
    reset = 1'b0;
    #1;
    check_eq("ready_after_rst", 64'(bus.cpu_req_ready), 64'd1);
    @(posedge clk); #1;

    // Cold miss then hit on the same word
    do_load("cold", 64'h1008, 64'hAA, 1'b0);
    check_eq("cold_fill_addr", fill_addr_log, 64'h1000);
    do_load("hit", 64'h1008, 64'hAA, 1'b1);
    check_eq("hit_no_fill", 64'(fill_cnt), 64'd1);

    // Partial store hit, then read back the merged word
    do_store("st", 64'h1010, 64'hFFFF, 8'h03);
    do_load("merged", 64'h1010, 64'h1122_3344_5566_FFFF, 1'b1);

    // Conflict miss evicts the dirty line
    do_load("conflict", 64'h2000, 64'h2000, 1'b0);
    check_eq("wb_cnt", 64'(wb_cnt), 64'd1);
    check_eq("wb_addr", wb_addr_log, 64'h1000);
    check_eq("wb_w2", wb_line_log[128 +: 64], 64'h1122_3344_5566_FFFF);
    check_eq("wb_w1", wb_line_log[64 +: 64], 64'hAA);
    check_eq("conflict_fill", fill_addr_log, 64'h2000);

    // Clean victim: refetch of the written-back line, no second writeback
    do_load("refetch", 64'h1010, 64'h1122_3344_5566_FFFF, 1'b0);
    check_eq("clean_no_wb", 64'(wb_cnt), 64'd1);

    // Snoop drops a dirty resident line without writing it back
    do_store("st2", 64'h1000, 64'h55, 8'h01);
    inv_pulse(64'h1000);
    f0 = fill_cnt;
    do_load("after_inv", 64'h1008, 64'hAA, 1'b0);
    check_eq("inv_refill", 64'(fill_cnt), 64'(f0 + 1));
    check_eq("inv_no_wb", 64'(wb_cnt), 64'd1);
    do_load("inv_lost_store", 64'h1000, 64'h1000, 1'b1);

    // Snoop of the line during its own fill: response delivered, line not kept
    fork
      do_load("poison", 64'h3008, 64'h3008, 1'b0);
      begin
        wait_fill(64'h3000);
        inv_pulse(64'h3000);
      end
    join
    f0 = fill_cnt;
    do_load("after_poison", 64'h3008, 64'h3008, 1'b0);
    check_eq("poison_refill", 64'(fill_cnt), 64'(f0 + 1));

    // Reset in the middle of a fill
    do_load("idx1", 64'h1048, 64'h1048, 1'b0);
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_store = 1'b0;
    bus.cpu_req_addr  = 64'h4008;
    @(posedge clk); #1;
    bus.cpu_req_valid = 1'b0;
    wait_fill(64'h4000);
    reset = 1'b1;
    #1;
    check_eq("midrst_cmd", 64'(bus.mem_cmd_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_eq("postrst_ready", 64'(bus.cpu_req_ready), 64'd1);
    check_eq("postrst_cmd", 64'(bus.mem_cmd_valid), 64'd0);
    @(posedge clk); #1;
    f0 = fill_cnt;
    do_load("postrst_miss", 64'h1048, 64'h1048, 1'b0);
    check_eq("postrst_refill", 64'(fill_cnt), 64'(f0 + 1));

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/l1_dcache_direct.md
# l1_dcache_direct

Direct-mapped, write-back, write-allocate L1 data cache placed between the core load/store unit and one connection of the shared cache-to-memory bus arbiter. It serves word accesses from flop-based tag/data arrays. On a miss it writes back a dirty victim line, then fetches the whole line through the arbiter's line-granular command interface. It honours the arbiter's snoop-invalidate pulses.

## Interface
Parameters:
- DATA_WIDTH, 64, word width; bus beat width.
- ADDR_WIDTH, 64, address width.
- CHUNKS_LOG, 3, log2 of words per line; default gives 8 words, 64 B.
- SETS, 64, number of lines; power of two.

Ports:
- Clocking: clk and reset are decided. reset is synchronous and active-high; clock is clk.
- cpu_req_valid  in  1  request present.
- cpu_req_ready  out  1  high only in IDLE.
- cpu_req_store  in  1  1 = store, 0 = load.
- cpu_req_addr  in  ADDR_WIDTH  byte address; word-aligned.
- cpu_req_wdata  in  DATA_WIDTH  store data.
- cpu_req_wstrb  in  DATA_WIDTH/8  store byte enables.
- cpu_resp_valid  out  1  one-cycle completion pulse for loads and stores.
- cpu_resp_rdata  out  DATA_WIDTH  load data; 0 for stores.
- mem_cmd_valid  out  1  line command to the arbiter.
- mem_cmd_store  out  1  1 = writeback, 0 = fill.
- mem_cmd_rready  out  1  fill line consumed.
- mem_cmd_addr  out  ADDR_WIDTH  line-aligned address.
- mem_cmd_line  out  DATA_WIDTH<<CHUNKS_LOG  victim line for writeback.
- mem_bus_valid  in  1  fill line available.
- mem_bus_ready  in  1  arbiter idle and last-served this port.
- mem_bus_line  in  DATA_WIDTH<<CHUNKS_LOG  fill data; word 0 in the LSBs.
- inv_valid  in  1  snoop invalidate pulse.
- inv_addr  in  ADDR_WIDTH  snooped address.

## Operation
- Address split, LSB first:
  - byte offset: log2(DATA_WIDTH/8) bits.
  - word select: CHUNKS_LOG bits.
  - index: log2(SETS) bits.
  - tag: all remaining bits.
- Per-line state: valid, dirty, tag, data. All valid and dirty bits clear on reset; data and tag are not reset.
- States: IDLE, LOOKUP, WB_REQ, WB_WAIT, FILL, RESP.
- IDLE:
  - cpu_req_ready=1.
  - On cpu_req_valid, register the request and go to LOOKUP.
- LOOKUP:
  - Hit = valid and tag match and not an invalidate of the same line this cycle.
  - Load hit: cpu_resp_valid=1 with the selected word; go to IDLE.
  - Store hit: merge wdata under wstrb, set dirty, pulse cpu_resp_valid; go to IDLE.
  - Miss with victim valid and dirty: go to WB_REQ. Otherwise go to FILL.
- WB_REQ:
  - mem_cmd_valid=1, mem_cmd_store=1, addr = {victim tag, index, 0}, line = victim data.
  - Hold until mem_bus_ready==0 is sampled (arbiter has taken the command), then go to WB_WAIT.
- WB_WAIT:
  - mem_cmd_valid=0.
  - When mem_bus_ready==1, clear dirty and go to FILL.
- FILL:
  - mem_cmd_valid=1, mem_cmd_store=0, addr = {req tag, index, 0}.
  - When mem_bus_valid==1: drive mem_cmd_rready=1 that same cycle; install the line, merging store data if the request is a store; set the tag; set valid unless poisoned; set dirty=store. Go to RESP.
- RESP: pulse cpu_resp_valid, with rdata from the installed line for loads; go to IDLE.
- Invalidate, any state: if inv_addr index/tag match a valid line, clear valid and dirty. No writeback is performed.
- Invalidate matching the line being filled while in FILL: set a poison flag. The fill still completes and responds, but the line is installed with valid=0.
- Invalidate matching the victim during WB_REQ/WB_WAIT: the writeback continues unchanged.

## Timing
- Reset: all outputs 0, state IDLE, poison flag cleared.
  - cpu_req_ready returns to 1 the first cycle after reset deasserts.
  - Reset mid-transaction abandons the transaction; the arbiter shares the same reset.
- Hit latency: request accepted at cycle N, cpu_resp_valid at N+1. Throughput is one access per 2 cycles.
- Miss latency: 2 + fill latency. A dirty miss adds the writeback round trip.
- mem_cmd_valid and mem_cmd_addr are registered-state decodes, stable for the whole WB_REQ/FILL stay.
- mem_cmd_valid drops on the cycle after mem_bus_valid, so the arbiter cannot re-accept the fill.
- cpu_resp_valid is never asserted for more than one cycle per request.

## Structure
- Package l1_dcache_pkg:
  - state enum.
  - localparams for offset/word/index/tag widths.
  - function for line-address formation.
  - function for strobe merge.
- Sub-module l1_dcache_tag_array: valid/dirty/tag flops, lookup compare, invalidate match and clear port.
- Data array stays inline in the top module.

## Test plan
- Cold load 0x1008 -> FILL issues mem_cmd_addr 0x1000. Fill word1=0xAA. Then resp rdata=0xAA; a second load of 0x1008 hits, with resp at N+1.
- Store 0x1010 wdata 0xFFFF, wstrb 0x03 to a resident line -> bytes 0-1 updated, dirty=1. A load then returns the merged word.
- Load 0x2000 to the same index as the dirty line 0x1000 (SETS=64) -> WB_REQ with mem_cmd_store=1, addr 0x1000, line carrying the store data. Then a fill of 0x2000.
- inv_valid addr 0x1000 while the line is resident -> the next load of 0x1000 misses and refetches.
- Invalidate of 0x3000 during its own FILL -> response still delivered; the following load of 0x3000 misses.
- reset asserted in FILL -> the cycle after: mem_cmd_valid=0, cpu_req_ready=1, all lines invalid.
